// File: rtl/exc_redirect_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exc_redirect_ctrl_if                                            |
// | Brief    : Commit-stage events, IF/AXI instruction-side handshakes and     |
// |            redirect outputs of the exception redirect controller.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface exc_redirect_ctrl_if #(
    parameter int CNT_W = 2
);
    logic             exc_oc;
    logic             ec_eret;
    logic [31:0]      cp0_epc;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic             redirect_ready;
    logic             flush;
    logic             fetch_hold;
    logic             drop_resp;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             busy;
    logic [CNT_W-1:0] outstanding;

    // Controller side
    modport master (
        input  exc_oc, ec_eret, cp0_epc, inst_addr_ok, inst_data_ok, redirect_ready,
        output flush, fetch_hold, drop_resp, redirect_valid, redirect_pc, busy, outstanding
    );

    // Commit stage / IF stage side
    modport slave (
        output exc_oc, ec_eret, cp0_epc, inst_addr_ok, inst_data_ok, redirect_ready,
        input  flush, fetch_hold, drop_resp, redirect_valid, redirect_pc, busy, outstanding
    );
endinterface
`default_nettype wire

// File: rtl/exc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exc_redirect_ctrl                                               |
// | Brief    : Flush, drain in-flight fetches, then redirect IF to the         |
// |            exception vector or EPC after an exception/ERET commits.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC0_0380,
    parameter int          MAX_OUTSTANDING = 3,
    parameter int          CNT_W           = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    exc_redirect_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [31:0]      r_target;
    logic [31:0]      w_target_nxt;

    // Saturating in-flight counter; a response with nothing in flight is absorbed.
    always_comb begin
        w_count_nxt = r_count;
        if (bus.inst_addr_ok && !bus.inst_data_ok) begin
            if (r_count != c_max_cnt) begin
                w_count_nxt = r_count + c_one;
            end
        end else if (!bus.inst_addr_ok && bus.inst_data_ok) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - c_one;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE: begin
                if (bus.exc_oc) begin
                    w_target_nxt = EXC_VECTOR;
                    w_state_nxt  = ST_FLUSH;
                end else if (bus.ec_eret) begin
                    w_target_nxt = bus.cp0_epc;
                    w_state_nxt  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The response that empties the bus releases the redirect in the same cycle.
                if (w_count_nxt == '0) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
        end
    end

    assign bus.flush          = (r_state == ST_FLUSH);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.fetch_hold     = (r_state != ST_IDLE) || (r_count == c_max_cnt);
    assign bus.drop_resp      = bus.inst_data_ok && ((r_state == ST_FLUSH) || (r_state == ST_DRAIN));
    assign bus.redirect_valid = (r_state == ST_REDIRECT);
    assign bus.redirect_pc    = r_target;
    assign bus.outstanding    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_exc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_exc_redirect_ctrl                                            |
// | Brief    : Directed vector table, backpressure sequence and random run     |
// |            against a cycle-level reference model.                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_exc_redirect_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam logic [31:0] E1   = 32'h8000_1234;
    localparam logic [31:0] E2   = 32'h1234_5678;
    localparam int          MAXO = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    exc_redirect_ctrl_if #(.CNT_W(2)) bus ();

    exc_redirect_ctrl #(
        .EXC_VECTOR      (VEC),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // i = {rst, exc, eret, aok, dok, rdy}; o = {flush, hold, drop, rv, busy}
    typedef struct {
        logic [5:0]  i;
        logic [31:0] epc;
        logic [4:0]  o;
        logic [31:0] pc;
        logic [1:0]  oc;
    } vec_t;

    function automatic vec_t v(logic [5:0] i, logic [31:0] epc, logic [4:0] o,
                               logic [31:0] pc, logic [1:0] oc);
        vec_t r;
        r.i = i; r.epc = epc; r.o = o; r.pc = pc; r.oc = oc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] i, input logic [31:0] epc);
        {reset, bus.exc_oc, bus.ec_eret, bus.inst_addr_ok, bus.inst_data_ok, bus.redirect_ready} = i;
        bus.cp0_epc = epc;
    endtask

    // Reference model: sequence activity, cycles since the event, and in-flight count.
    bit          m_active = 1'b0;
    bit          m_redir  = 1'b0;
    int          m_age    = 0;
    int          m_cnt    = 0;
    logic [31:0] m_target = 32'h0;

    task automatic model_update();
        int nc;
        nc = m_cnt + int'(bus.inst_addr_ok) - int'(bus.inst_data_ok);
        if (nc < 0)    nc = 0;
        if (nc > MAXO) nc = MAXO;
        if (reset) begin
            m_active = 1'b0; m_redir = 1'b0; m_age = 0; m_cnt = 0; m_target = 32'h0;
        end else begin
            if (!m_active) begin
                if (bus.exc_oc || bus.ec_eret) begin
                    m_active = 1'b1;
                    m_age    = 1;
                    m_target = bus.exc_oc ? VEC : bus.cp0_epc;
                end
            end else if (m_redir) begin
                if (bus.redirect_ready) begin
                    m_active = 1'b0;
                    m_redir  = 1'b0;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (nc == 0) begin
                m_redir = 1'b1;
            end
            m_cnt = nc;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " flush"},  32'(bus.flush),          32'(m_active && m_age == 1));
        chk({tag, " hold"},   32'(bus.fetch_hold),     32'(m_active || m_cnt == MAXO));
        chk({tag, " drop"},   32'(bus.drop_resp),      32'(bus.inst_data_ok && m_active && !m_redir));
        chk({tag, " rvalid"}, 32'(bus.redirect_valid), 32'(m_redir));
        chk({tag, " rpc"},    bus.redirect_pc,         m_target);
        chk({tag, " busy"},   32'(bus.busy),           32'(m_active));
        chk({tag, " outst"},  32'(bus.outstanding),    32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        // Reset, exception, ERET with late EPC change, counter saturation,
        // two-request drain, reset mid-drain.
        tbl.push_back(v(6'b100001, 32'h0,        5'b00000, 32'h0, 2'd0));
        tbl.push_back(v(6'b010001, 32'h0,        5'b00000, 32'h0, 2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b11001, VEC,   2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b01001, VEC,   2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b01011, VEC,   2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b00000, VEC,   2'd0));
        tbl.push_back(v(6'b001001, E1,           5'b00000, VEC,   2'd0));
        tbl.push_back(v(6'b000001, 32'hDEADBEEF, 5'b11001, E1,    2'd0));
        tbl.push_back(v(6'b000001, 32'hDEADBEEF, 5'b01001, E1,    2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b01011, E1,    2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b00000, E1,    2'd0));
        tbl.push_back(v(6'b000101, 32'h0,        5'b00000, E1,    2'd0));
        tbl.push_back(v(6'b000111, 32'h0,        5'b00000, E1,    2'd1));
        tbl.push_back(v(6'b000101, 32'h0,        5'b00000, E1,    2'd1));
        tbl.push_back(v(6'b000101, 32'h0,        5'b00000, E1,    2'd2));
        tbl.push_back(v(6'b000101, 32'h0,        5'b01000, E1,    2'd3));
        tbl.push_back(v(6'b000011, 32'h0,        5'b01000, E1,    2'd3));
        tbl.push_back(v(6'b010001, 32'h0,        5'b00000, E1,    2'd2));
        tbl.push_back(v(6'b000001, 32'h0,        5'b11001, VEC,   2'd2));
        tbl.push_back(v(6'b000001, 32'h0,        5'b01001, VEC,   2'd2));
        tbl.push_back(v(6'b000011, 32'h0,        5'b01101, VEC,   2'd2));
        tbl.push_back(v(6'b000001, 32'h0,        5'b01001, VEC,   2'd1));
        tbl.push_back(v(6'b000011, 32'h0,        5'b01101, VEC,   2'd1));
        tbl.push_back(v(6'b000001, 32'h0,        5'b01011, VEC,   2'd0));
        tbl.push_back(v(6'b000101, 32'h0,        5'b00000, VEC,   2'd0));
        tbl.push_back(v(6'b001001, E2,           5'b00000, VEC,   2'd1));
        tbl.push_back(v(6'b000001, 32'h0,        5'b11001, E2,    2'd1));
        tbl.push_back(v(6'b100001, 32'h0,        5'b01001, E2,    2'd1));
        tbl.push_back(v(6'b000001, 32'h0,        5'b00000, 32'h0, 2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b00000, 32'h0, 2'd0));
        tbl.push_back(v(6'b000001, 32'h0,        5'b00000, 32'h0, 2'd0));

        foreach (tbl[k]) begin
            drive(tbl[k].i, tbl[k].epc);
            @(negedge clk);
            chk($sformatf("row%0d flush", k),  32'(bus.flush),          32'(tbl[k].o[4]));
            chk($sformatf("row%0d hold", k),   32'(bus.fetch_hold),     32'(tbl[k].o[3]));
            chk($sformatf("row%0d drop", k),   32'(bus.drop_resp),      32'(tbl[k].o[2]));
            chk($sformatf("row%0d rvalid", k), 32'(bus.redirect_valid), 32'(tbl[k].o[1]));
            chk($sformatf("row%0d busy", k),   32'(bus.busy),           32'(tbl[k].o[0]));
            chk($sformatf("row%0d rpc", k),    bus.redirect_pc,         tbl[k].pc);
            chk($sformatf("row%0d outst", k),  32'(bus.outstanding),    32'(tbl[k].oc));
            tick();
        end

        // Priority plus backpressure: both events together, IF stalls the redirect.
        drive(6'b011000, 32'h1111_2222);
        @(negedge clk); tick();
        drive(6'b000000, 32'h1111_2222);
        @(negedge clk); chk("bp flush", 32'(bus.flush), 32'd1); tick();
        @(negedge clk); chk("bp drain rvalid", 32'(bus.redirect_valid), 32'd0); tick();
        for (int c = 0; c < 5; c++) begin
            bus.exc_oc = (c == 1);
            @(negedge clk);
            chk($sformatf("bp%0d rvalid", c), 32'(bus.redirect_valid), 32'd1);
            chk($sformatf("bp%0d rpc", c),    bus.redirect_pc,         VEC);
            chk($sformatf("bp%0d flush", c),  32'(bus.flush),          32'd0);
            tick();
        end
        bus.exc_oc = 1'b0;
        bus.redirect_ready = 1'b1;
        @(negedge clk); chk("bp accept rvalid", 32'(bus.redirect_valid), 32'd1); tick();
        bus.redirect_ready = 1'b0;
        @(negedge clk);
        chk("bp after rvalid", 32'(bus.redirect_valid), 32'd0);
        chk("bp after busy",   32'(bus.busy),           32'd0);
        tick();
        @(negedge clk); chk("bp ignored busy", 32'(bus.busy), 32'd0); tick();

        // Random traffic against the model.
        drive(6'b100000, 32'h0);
        @(negedge clk); tick();
        for (int c = 0; c < 3000; c++) begin
            reset              = ($urandom_range(0, 199) == 0);
            bus.exc_oc         = ($urandom_range(0, 15) == 0);
            bus.ec_eret        = ($urandom_range(0, 15) == 0);
            bus.cp0_epc        = $urandom;
            bus.inst_addr_ok   = ($urandom_range(0, 2) == 0);
            bus.inst_data_ok   = ($urandom_range(0, 2) == 0);
            bus.redirect_ready = ($urandom_range(0, 1) == 0);
            @(negedge clk);
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
